// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus_arb arbiter.
package bus_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Width of a counter that must hold 0..max_burst inclusive.
  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simple_if.sv
// Single-port memory bus: write and read requests share one address.
// Read data returns the cycle after rd_req.
interface simple_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8
);
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      wr_req;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic                      rd_req;
  logic [DATA_BIT_WIDTH-1:0] rd_data;

  modport mst_port (output addr, wr_req, wr_data, rd_req, input rd_data);
  modport slv_port (input addr, wr_req, wr_data, rd_req, output rd_data);
endinterface

// File: rtl/bus_arb_rr_pick.sv
// Combinational winner selection for bus_arb.
// Default: round robin, scanning from ptr+1 upward with wrap-around.
// BUS_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, ptr ignored.
module bus_arb_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             vld
);

  logic [N_REQ-1:0] pick_src;
  logic             found;

`ifdef BUS_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign pick_src   = req;
`else
  logic [N_REQ-1:0] hi_req;

  // Requesters above the pointer take precedence; otherwise wrap to the bottom.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    hi_req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_req[i] = req[i] && (i > int'(ptr));
    end
  end

  assign pick_src = (|hi_req) ? hi_req : req;
`endif

  // Lowest set bit of the selected request vector becomes the one-hot winner.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_src[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign vld = |req;

endmodule

// File: rtl/bus_arb.sv
// Round-robin arbiter with burst lock sharing one simple_if slave between N_REQ
// requesters. The owner keeps the bus while it requests, up to MAX_BURST accesses.
// Optional build macro: BUS_ARB_FIXED_PRIO_EN (fixed priority, lowest index wins).
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int MAX_BURST      = 4
) (
  input  logic                              i_clk,
  input  logic                              i_sync_rst,
  input  logic [N_REQ-1:0]                  i_req,
  input  logic [N_REQ-1:0]                  i_we,
  input  logic [N_REQ*ADDR_BIT_WIDTH-1:0]   i_addr,
  input  logic [N_REQ*DATA_BIT_WIDTH-1:0]   i_wr_data,
  output logic [N_REQ-1:0]                  o_gnt,
  output logic [N_REQ-1:0]                  o_rd_vld,
  output logic [DATA_BIT_WIDTH-1:0]         o_rd_data,
  simple_if.mst_port                        if_bus
);

  localparam int                BEAT_W    = beat_cnt_width(MAX_BURST);
  localparam int                IDX_W     = idx_width(N_REQ);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("bus_arb: MAX_BURST must be >= 1");
  end
  if (N_REQ < 2) begin : g_bad_nreq
    $error("bus_arb: N_REQ must be >= 2");
  end

  arb_state_e              state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [N_REQ-1:0]        rd_vld_q, rd_vld_d;

  logic [IDX_W-1:0]        owner_idx;
  logic [N_REQ-1:0]        own_req;
  logic                    access;
  logic [BEAT_W-1:0]       beat_inc;
  logic                    release_bus;
  logic [IDX_W-1:0]        pick_ptr;
  logic [N_REQ-1:0]        pick_gnt;
  logic                    pick_vld;
  logic [ADDR_BIT_WIDTH-1:0] bus_addr;
  logic [DATA_BIT_WIDTH-1:0] bus_wdata;

  // Binary index of the current owner, decoded from the one-hot grant.
  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) owner_idx = IDX_W'(k);
    end
  end

  // Only the owner's request counts; everything else is ignored.
  assign own_req     = gnt_q & i_req;
  assign access      = |own_req;
  assign beat_inc    = beat_q + 1'b1;
  assign release_bus = (state_q == ARB_GRANT) && (!access || (beat_inc == BEAT_LAST));

  // While granted, the owner is the lowest-priority candidate for the next pick.
  assign pick_ptr = (state_q == ARB_GRANT) ? owner_idx : ptr_q;

  bus_arb_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (i_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  // Route the owner's address and write data to the slave; zero when no access.
  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (own_req[k]) begin
        bus_addr  = i_addr[k*ADDR_BIT_WIDTH +: ADDR_BIT_WIDTH];
        bus_wdata = i_wr_data[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      end
    end
  end

  assign if_bus.addr    = bus_addr;
  assign if_bus.wr_data = bus_wdata;
  assign if_bus.wr_req  = |(own_req & i_we);
  assign if_bus.rd_req  = |(own_req & ~i_we);

  // Next-state logic: grant on idle, burst counting, release and hand-over.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    beat_d   = beat_q;
    rd_vld_d = own_req & ~i_we;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_gnt;
          beat_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (release_bus) begin
          ptr_d  = owner_idx;
          beat_d = '0;
          if (pick_vld) begin
            gnt_d = pick_gnt;
          end else begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
          end
        end else if (access) begin
          beat_d = beat_inc;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset; the pending read return is dropped.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_sync_rst) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      ptr_q    <= IDX_W'(N_REQ - 1);
      beat_q   <= '0;
      rd_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_rd_vld  = rd_vld_q;
  // Slave read data is already registered; pass it through only while qualified.
  assign o_rd_data = (|rd_vld_q) ? if_bus.rd_data : '0;

endmodule
